// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity mode constants and the
// 3-sample majority helper used by the optional rx filter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    RECOV = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop rx synchroniser; with UART_RX_MAJORITY_EN defined the sample bit is the
// majority of the last three s_tick samples of rx_s, otherwise it is rx_s itself.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic s_tick,
  output logic rx_s,
  output logic sample
);

  logic [1:0] sync_r;

  // metastability guard, idles high like the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  assign rx_s = sync_r[1];

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_r;

  // history of rx_s taken at each s_tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_r <= 3'b111;
    end else if (s_tick) begin
      hist_r <= {hist_r[1:0], rx_s};
    end else begin
      hist_r <= hist_r;
    end
  end

  // at a sample tick the current rx_s is the newest of the three votes
  assign sample = maj3({hist_r[1:0], rx_s});
`else
  logic unused_tick;
  assign unused_tick = s_tick;
  assign sample      = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1/1.5/2 stop).
// Optional feature: define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int OVS         = 16,
  parameter int SB_TICK     = 16,
  parameter int PARITY_MODE = PARITY_NONE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD_FLIP = (PARITY_MODE == PARITY_ODD);
  localparam rx_state_t     AFTER_DATA = (PARITY_MODE != PARITY_NONE) ? PAR : STOP;

  logic rx_s;
  logic sample;

  rx_state_t       state_r, state_n;
  logic [SW-1:0]   s_r, s_n;
  logic [NW-1:0]   n_r, n_n;
  logic [DBIT-1:0] b_r, b_n;
  logic            perr_r, perr_n;
  logic            ferr_r, ferr_n;
  logic            done_n;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .s_tick (s_tick),
    .rx_s   (rx_s),
    .sample (sample)
  );

  // next-state and datapath decode; everything except IDLE/RECOV waits on s_tick
  always_comb begin
    state_n = state_r;
    s_n     = s_r;
    n_n     = n_r;
    b_n     = b_r;
    perr_n  = perr_r;
    ferr_n  = ferr_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = {SW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (s_tick && (s_r == S_HALF)) begin
          if (sample) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            s_n     = {SW{1'b0}};
            n_n     = {NW{1'b0}};
          end
        end else if (s_tick) begin
          s_n = s_r + 1'b1;
        end else begin
          s_n = s_r;
        end
      end
      DATA: begin
        if (s_tick && (s_r == S_LAST)) begin
          s_n = {SW{1'b0}};
          b_n = {sample, b_r[DBIT-1:1]};
          if (n_r == N_LAST) begin
            state_n = AFTER_DATA;
          end else begin
            n_n = n_r + 1'b1;
          end
        end else if (s_tick) begin
          s_n = s_r + 1'b1;
        end else begin
          s_n = s_r;
        end
      end
      PAR: begin
        if (s_tick && (s_r == S_LAST)) begin
          s_n     = {SW{1'b0}};
          perr_n  = (^{b_r, sample}) ^ ODD_FLIP;
          state_n = STOP;
        end else if (s_tick) begin
          s_n = s_r + 1'b1;
        end else begin
          s_n = s_r;
        end
      end
      STOP: begin
        // with SB_TICK == OVS the stop sample and completion share one tick
        if (s_tick && (s_r == S_LAST)) begin
          ferr_n = ~sample;
        end else begin
          ferr_n = ferr_r;
        end
        if (s_tick && (s_r == S_STOP)) begin
          done_n  = 1'b1;
          s_n     = {SW{1'b0}};
          state_n = ferr_n ? RECOV : IDLE;
        end else if (s_tick) begin
          s_n = s_r + 1'b1;
        end else begin
          s_n = s_r;
        end
      end
      RECOV: begin
        if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = RECOV;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state, counters and the output words that hold between frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      s_r          <= {SW{1'b0}};
      n_r          <= {NW{1'b0}};
      b_r          <= {DBIT{1'b0}};
      perr_r       <= 1'b0;
      ferr_r       <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= {DBIT{1'b0}};
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_r      <= state_n;
      s_r          <= s_n;
      n_r          <= n_n;
      b_r          <= b_n;
      perr_r       <= perr_n;
      ferr_r       <= ferr_n;
      rx_done_tick <= done_n;
      if (done_n) begin
        dout       <= b_r;
        parity_err <= perr_r;
        frame_err  <= ferr_n;
      end else begin
        dout       <= dout;
        parity_err <= parity_err;
        frame_err  <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised and directed bench for uart_rx_cfg over four parameter sets, checked
// against a frame-level model (data, parity arithmetic, stop level, completion time).
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int OVS = 16;
  localparam int NI  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            s_tick = 1'b0;
  logic [1:0]      div = 2'd0;
  logic [NI-1:0]   rx = '1;
  logic [NI-1:0]   done, perr, ferr;
  logic [7:0]      dout0, dout1;
  logic [6:0]      dout2;
  logic [4:0]      dout3;
  logic [8:0]      dw [NI];

  int unsigned     tick_cnt = 0;
  int unsigned     done_cnt [NI];
  int unsigned     last_tk [NI];
  logic [8:0]      last_d [NI];
  logic            last_pe [NI];
  logic            last_fe [NI];
  logic [NI-1:0]   prev_done = '0;
  int              bb_viol = 0;
  int              n_chk = 0;
  int              n_fail = 0;

  uart_rx_cfg #(.DBIT(8), .OVS(OVS), .SB_TICK(16), .PARITY_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .rx(rx[0]), .s_tick(s_tick),
    .rx_done_tick(done[0]), .dout(dout0), .parity_err(perr[0]), .frame_err(ferr[0]));
  uart_rx_cfg #(.DBIT(8), .OVS(OVS), .SB_TICK(16), .PARITY_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .rx(rx[1]), .s_tick(s_tick),
    .rx_done_tick(done[1]), .dout(dout1), .parity_err(perr[1]), .frame_err(ferr[1]));
  uart_rx_cfg #(.DBIT(7), .OVS(OVS), .SB_TICK(32), .PARITY_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .rx(rx[2]), .s_tick(s_tick),
    .rx_done_tick(done[2]), .dout(dout2), .parity_err(perr[2]), .frame_err(ferr[2]));
  uart_rx_cfg #(.DBIT(5), .OVS(OVS), .SB_TICK(24), .PARITY_MODE(2)) dut3 (
    .clk(clk), .reset(reset), .rx(rx[3]), .s_tick(s_tick),
    .rx_done_tick(done[3]), .dout(dout3), .parity_err(perr[3]), .frame_err(ferr[3]));

  assign dw[0] = {1'b0, dout0};
  assign dw[1] = {1'b0, dout1};
  assign dw[2] = {2'b00, dout2};
  assign dw[3] = {4'b0000, dout3};

  always #5 clk = ~clk;

  // one s_tick every fourth clock, launched away from the active edge
  always @(negedge clk) begin
    div    <= div + 2'd1;
    s_tick <= (div == 2'd2);
  end

  always @(posedge clk) begin
    if (s_tick) tick_cnt <= tick_cnt + 1;
  end

  // completion monitor per receiver
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (done[i]) begin
        if (prev_done[i]) bb_viol <= bb_viol + 1;
        done_cnt[i] <= done_cnt[i] + 1;
        last_d[i]   <= dw[i];
        last_pe[i]  <= perr[i];
        last_fe[i]  <= ferr[i];
        last_tk[i]  <= tick_cnt;
      end
      prev_done[i] <= done[i];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int cfg_dbit(input int i);
    case (i)
      2:       return 7;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_pm(input int i);
    case (i)
      1:       return 1;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(input int i);
    case (i)
      2:       return 32;
      3:       return 24;
      default: return 16;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
    #1;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) wait_tick();
  endtask

  // drive one frame, then compare the receiver's report with the frame model
  task automatic send_frame(input int idx, input logic [8:0] data, input logic pbit,
                            input logic stop_ok, input int low_ticks, input logic glitch);
    int          db, pm, sb, ones;
    int unsigned cnt0, t0;
    logic [8:0]  exp_d;
    logic        exp_pe;
    db   = cfg_dbit(idx);
    pm   = cfg_pm(idx);
    sb   = cfg_sb(idx);
    cnt0 = done_cnt[idx];
    wait_tick();
    t0 = tick_cnt;
    rx[idx] = 1'b0;
    hold(OVS);
    for (int i = 0; i < db; i++) begin
      rx[idx] = data[i];
      if (glitch && i == 0) begin
        hold(OVS / 2 - 1);
        rx[idx] = ~data[0];
        hold(1);
        rx[idx] = data[0];
        hold(OVS / 2);
      end else begin
        hold(OVS);
      end
    end
    if (pm != 0) begin
      rx[idx] = pbit;
      hold(OVS);
    end
    if (stop_ok) begin
      rx[idx] = 1'b1;
      hold(sb + 4);
    end else begin
      rx[idx] = 1'b0;
      hold(low_ticks);
      rx[idx] = 1'b1;
      hold(4);
    end
    ones = 0;
    exp_d = 9'd0;
    for (int i = 0; i < db; i++) begin
      ones += int'(data[i]);
      exp_d[i] = data[i];
    end
    if (glitch) begin
`ifndef UART_RX_MAJORITY_EN
      exp_d[0] = ~data[0];
      ones += (data[0] ? -1 : 1);
`endif
    end
    if (pm == 1)      exp_pe = ((ones + int'(pbit)) % 2) == 1;
    else if (pm == 2) exp_pe = ((ones + int'(pbit)) % 2) == 0;
    else              exp_pe = 1'b0;
    check_eq($sformatf("done_count[%0d]", idx), done_cnt[idx] - cnt0, 32'd1);
    check_eq($sformatf("dout[%0d]", idx), {23'd0, last_d[idx]}, {23'd0, exp_d});
    check_eq($sformatf("parity_err[%0d]", idx), {31'd0, last_pe[idx]}, {31'd0, exp_pe});
    check_eq($sformatf("frame_err[%0d]", idx), {31'd0, last_fe[idx]}, {31'd0, ~stop_ok});
    check_eq($sformatf("done_time[%0d]", idx), last_tk[idx] - t0,
             OVS / 2 + (db + ((pm != 0) ? 1 : 0)) * OVS + sb);
  endtask

  initial begin
    int unsigned cnt0;
    for (int i = 0; i < NI; i++) begin
      done_cnt[i] = 0;
      last_tk[i]  = 0;
      last_d[i]   = 9'd0;
      last_pe[i]  = 1'b0;
      last_fe[i]  = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("reset_outs[%0d]", i), {20'd0, dw[i], done[i], perr[i], ferr[i]}, 32'd0);
    end
    reset = 1'b1;
    hold(4);

    send_frame(0, 9'h0A5, 1'b0, 1'b1, 0, 1'b0);

    cnt0 = done_cnt[0];
    wait_tick();
    rx[0] = 1'b0;
    hold(4);
    rx[0] = 1'b1;
    hold(2 * OVS);
    check_eq("false_start_done", done_cnt[0] - cnt0, 32'd0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 0, 1'b0);

    send_frame(1, 9'h003, 1'b1, 1'b1, 0, 1'b0);
    send_frame(1, 9'h003, 1'b0, 1'b1, 0, 1'b0);

    send_frame(0, 9'h055, 1'b0, 1'b0, 40 * OVS, 1'b0);
    send_frame(0, 9'h012, 1'b0, 1'b1, 0, 1'b0);

    // abort a frame in data bit 3 with an asynchronous reset
    cnt0 = done_cnt[0];
    wait_tick();
    rx[0] = 1'b0;
    hold(OVS);
    for (int i = 0; i < 3; i++) begin
      rx[0] = 1'b1;
      hold(OVS);
    end
    hold(OVS / 2);
    reset = 1'b0;
    #1;
    check_eq("midframe_reset_outs", {20'd0, dw[0], done[0], perr[0], ferr[0]}, 32'd0);
    rx[0] = 1'b1;
    hold(2);
    reset = 1'b1;
    hold(2 * OVS);
    check_eq("midframe_reset_done", done_cnt[0] - cnt0, 32'd0);
    send_frame(0, 9'h081, 1'b0, 1'b1, 0, 1'b0);

    send_frame(0, 9'h000, 1'b0, 1'b1, 0, 1'b1);
    send_frame(2, 9'h07F, 1'b0, 1'b1, 0, 1'b0);
    send_frame(3, 9'h015, 1'b0, 1'b1, 0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      send_frame($urandom_range(0, NI - 1), 9'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0), OVS * $urandom_range(2, 4), 1'b0);
    end

    check_eq("done_pulse_width", bb_viol, 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
